// File: rtl/seq_mult_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mult_param_if                                                    |
// | Start/clear/operand request and busy/done/product response bundle.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seq_mult_param_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic               clear;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, clear, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, clear, a, b,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/seq_mult_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mult_param                                                       |
// | Repeated-addition sequential multiplier: IDLE/RUN/DONE control FSM.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_mult_param #(
  parameter int WIDTH    = 4,
  parameter int SWAP_MIN = 1,
  parameter int SIGNED   = 0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  seq_mult_param_if.slave  bus
);

  localparam logic [WIDTH-1:0]   c_one_w  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] c_one_2w = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_count;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_product;
  logic               r_sign;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_cnt_init;
  logic [WIDTH-1:0]   w_mc_init;
  logic               w_sign;

  // |most-negative| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_mag_a = bus.a[WIDTH-1] ? ((~bus.a) + c_one_w) : bus.a;
      assign w_mag_b = bus.b[WIDTH-1] ? ((~bus.b) + c_one_w) : bus.b;
      assign w_sign  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end else begin : g_unsigned
      assign w_mag_a = bus.a;
      assign w_mag_b = bus.b;
      assign w_sign  = 1'b0;
    end
  endgenerate

  // Iterating over the smaller magnitude bounds the RUN time.
  generate
    if (SWAP_MIN != 0) begin : g_swap
      assign w_cnt_init = (w_mag_a < w_mag_b) ? w_mag_a : w_mag_b;
      assign w_mc_init  = (w_mag_a < w_mag_b) ? w_mag_b : w_mag_a;
    end else begin : g_noswap
      assign w_cnt_init = w_mag_b;
      assign w_mc_init  = w_mag_a;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_mcand   <= '0;
      r_product <= '0;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (bus.clear) begin
      r_state   <= S_IDLE;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_count   <= w_cnt_init;
            r_mcand   <= {{WIDTH{1'b0}}, w_mc_init};
            r_sign    <= w_sign;
            r_product <= '0;
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_count != '0) begin
            r_product <= r_product + r_mcand;
            r_count   <= r_count - c_one_w;
          end else begin
            if (r_sign) begin
              r_product <= (~r_product) + c_one_2w;
            end
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_mult_param                                                    |
// | Three configurations (swap/unsigned, no-swap/unsigned, swap/signed). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seq_mult_param;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic [3:0] a;
  logic [3:0] b;
  int         sel;

  int n_cmp;
  int n_err;

  seq_mult_param_if #(.WIDTH(4)) bus0 ();
  seq_mult_param_if #(.WIDTH(4)) bus1 ();
  seq_mult_param_if #(.WIDTH(4)) bus2 ();

  seq_mult_param #(.WIDTH(4), .SWAP_MIN(1), .SIGNED(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_mult_param #(.WIDTH(4), .SWAP_MIN(0), .SIGNED(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  seq_mult_param #(.WIDTH(4), .SWAP_MIN(1), .SIGNED(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.start = start && (sel == 0);
  assign bus1.start = start && (sel == 1);
  assign bus2.start = start && (sel == 2);
  assign bus0.clear = clear;
  assign bus1.clear = clear;
  assign bus2.clear = clear;
  assign bus0.a = a;
  assign bus1.a = a;
  assign bus2.a = a;
  assign bus0.b = b;
  assign bus1.b = b;
  assign bus2.b = b;

  logic       w_busy;
  logic       w_done;
  logic [7:0] w_prod;
  assign w_busy = (sel == 0) ? bus0.busy    : (sel == 1) ? bus1.busy    : bus2.busy;
  assign w_done = (sel == 0) ? bus0.done    : (sel == 1) ? bus1.done    : bus2.done;
  assign w_prod = (sel == 0) ? bus0.product : (sel == 1) ? bus1.product : bus2.product;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         s;
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] p;
    int         n;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: true arithmetic product and the iteration count the rules imply.
  function automatic logic [7:0] ref_prod(input int s, input logic [3:0] x, input logic [3:0] y);
    int p;
    if (s == 2) p = int'($signed(x)) * int'($signed(y));
    else        p = int'(x) * int'(y);
    return p[7:0];
  endfunction

  function automatic int ref_n(input int s, input logic [3:0] x, input logic [3:0] y);
    int mx, my;
    if (s == 2) begin
      mx = int'($signed(x)); my = int'($signed(y));
      if (mx < 0) mx = -mx;
      if (my < 0) my = -my;
    end else begin
      mx = int'(x); my = int'(y);
    end
    if (s == 1) return my;
    return (mx < my) ? mx : my;
  endfunction

  task automatic wait_idle(output int nb);
    int guard;
    nb = 0;
    guard = 0;
    while (w_busy && guard < 40) begin
      nb++;
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input int s, input logic [3:0] ia, input logic [3:0] ib,
                        input logic [7:0] ep, input int en, input string nm);
    int nb;
    @(negedge clk);
    sel = s; a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);
    check(nb, en + 1, {nm, " busy_cycles"});
    check({31'd0, w_done}, 1, {nm, " done"});
    check({24'd0, w_prod}, {24'd0, ep}, {nm, " product"});
    @(negedge clk);
    check({31'd0, w_done}, 0, {nm, " done_drop"});
  endtask

  task automatic abort_test(input bit use_rst, input string nm);
    bit saw_done;
    @(negedge clk);
    sel = 0; a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    if (use_rst) rst_n = 1'b0;
    else         clear = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clear = 1'b0;
    check({30'd0, w_busy, w_done}, 0, {nm, " busy_done"});
    check({24'd0, w_prod}, 0, {nm, " product"});
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (w_done || w_busy) saw_done = 1'b1;
    end
    check({31'd0, saw_done}, 0, {nm, " no_done"});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [3:0] ra, rb;
    int rs;

    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{0, 4'd2,  4'd3,  8'd6,   2};
    vecs[1] = '{0, 4'd15, 4'd15, 8'hE1, 15};
    vecs[2] = '{1, 4'd15, 4'd1,  8'd15,  1};
    vecs[3] = '{1, 4'd3,  4'd15, 8'h2D, 15};
    vecs[4] = '{0, 4'd0,  4'd9,  8'd0,   0};
    vecs[5] = '{0, 4'd9,  4'd0,  8'd0,   0};
    vecs[6] = '{2, 4'hD,  4'd5,  8'hF1,  3};
    vecs[7] = '{2, 4'h8,  4'h8,  8'h40,  8};
    vecs[8] = '{2, 4'h8,  4'd7,  8'hC8,  7};

    // Reset wins over clear and start asserted together.
    sel = 0; a = 4'd3; b = 4'd2; start = 1'b1; clear = 1'b1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check({30'd0, w_busy, w_done}, 0, "reset busy_done");
    check({24'd0, w_prod}, 0, "reset product");
    start = 1'b0; clear = 1'b0; rst_n = 1'b1;
    run_op(0, 4'd3, 4'd2, 8'd6, 2, "post_reset");

    foreach (vecs[i])
      run_op(vecs[i].s, vecs[i].va, vecs[i].vb, vecs[i].p, vecs[i].n, $sformatf("vec%0d", i));

    // Start during DONE is dropped; product holds in IDLE.
    @(negedge clk);
    sel = 0; a = 4'd2; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);
    check({31'd0, w_done}, 1, "b2b first_done");
    a = 4'd5; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({30'd0, w_busy, w_done}, 0, "b2b ignored_start");
    check({24'd0, w_prod}, 6, "b2b held_product");
    run_op(0, 4'd5, 4'd5, 8'd25, 5, "b2b reissue");

    abort_test(1'b0, "abort_clear");
    abort_test(1'b1, "abort_rst");

    // Start pulsed mid-RUN with other operands must not disturb the result.
    @(negedge clk);
    sel = 0; a = 4'd4; b = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);
    check(nb, 3, "run_start remaining_busy");
    check({24'd0, w_prod}, 24, "run_start product");

    for (int k = 0; k < 30; k++) begin
      rs = int'($urandom_range(0, 2));
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(rs, ra, rb, ref_prod(rs, ra, rb), ref_n(rs, ra, rb),
             $sformatf("rnd%0d s%0d a%0h b%0h", k, rs, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
